// File: rtl/boot_loader.sv
// Serial boot loader: parses SYNC / length / little-endian words from a byte stream into instruction memory.
// Build option BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the CHK state.
//   state | meaning
//   IDLE  | waiting for SYNC_BYTE after reset
//   LEN   | next byte is the word count N
//   DATA  | assembling the current word, LSB first
//   WRITE | one-cycle memory write of the assembled word
//   CHK   | waiting for the checksum byte (checksum build only)
//   DONE  | frame loaded, processor released
//   ERR   | frame failed (timeout or bad checksum)
module boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        mem_write,
    output logic [9:0]  mem_address,
    output logic [31:0] mem_writedata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [7:0]  words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;
`endif

    state_t        r_state, w_next;
    logic [7:0]    r_len;
    logic [7:0]    r_words;
    logic [9:0]    r_addr;
    logic [23:0]   r_shift;
    logic [31:0]   r_wdata;
    logic [1:0]    r_byte_cnt;
    logic [TW-1:0] r_timer;

    logic w_sync, w_start, w_counting, w_timeout, w_last, w_take;

    assign w_sync  = rx_valid && (rx_byte == SYNC_BYTE);
    assign w_start = w_sync && (r_state == IDLE || r_state == DONE || r_state == ERR);
`ifdef BOOT_LOADER_CHECKSUM_EN
    assign w_counting = (r_state == LEN) || (r_state == DATA) || (r_state == CHK);
`else
    assign w_counting = (r_state == LEN) || (r_state == DATA);
`endif
    assign w_timeout = w_counting && !rx_valid && (r_timer == TW'(1));
    assign w_last    = (r_words + 8'd1) == r_len;
    // A byte landing in the final WRITE is not data: it is the checksum (or outside the frame).
    assign w_take    = rx_valid && ((r_state == DATA) || (r_state == WRITE && !w_last));

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       w_csum_ok;
    assign w_csum_ok = (rx_byte == r_csum);

    always_ff @(posedge clk) begin
        if (!rst_n)       r_csum <= '0;
        else if (w_start) r_csum <= '0;
        else if (w_take)  r_csum <= r_csum ^ rx_byte;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_write  = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (r_state)
            IDLE: if (w_sync) w_next = LEN;
            LEN: begin
                if (rx_valid) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    w_next = (rx_byte == 8'd0) ? CHK : DATA;
`else
                    w_next = (rx_byte == 8'd0) ? DONE : DATA;
`endif
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (r_byte_cnt == 2'd3) w_next = WRITE;
                end else if (w_timeout) begin
                    w_next = ERR;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                if (!w_last)       w_next = DATA;
`ifdef BOOT_LOADER_CHECKSUM_EN
                else if (rx_valid) w_next = w_csum_ok ? DONE : ERR;
                else               w_next = CHK;
`else
                else               w_next = DONE;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHK: begin
                if (rx_valid)       w_next = w_csum_ok ? DONE : ERR;
                else if (w_timeout) w_next = ERR;
            end
`endif
            DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (w_sync) w_next = LEN;
            end
            ERR: begin
                load_error = 1'b1;
                if (w_sync) w_next = LEN;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_words    <= '0;
            r_addr     <= '0;
            r_shift    <= '0;
            r_wdata    <= '0;
            r_byte_cnt <= '0;
            r_timer    <= '0;
        end else begin
            if (rx_valid)        r_timer <= TW'(TIMEOUT_CYCLES);
            else if (w_counting) r_timer <= r_timer - TW'(1);

            if (w_start) begin
                r_addr     <= '0;
                r_words    <= '0;
                r_byte_cnt <= '0;
            end
            if (r_state == LEN && rx_valid) r_len <= rx_byte;
            if (w_take) begin
                r_shift    <= {rx_byte, r_shift[23:8]};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (r_state == DATA && rx_valid && r_byte_cnt == 2'd3)
                r_wdata <= {rx_byte, r_shift};
            if (r_state == WRITE) begin
                r_addr  <= r_addr + 10'd4;
                r_words <= r_words + 8'd1;
            end
        end
    end

    assign mem_address   = r_addr;
    assign mem_writedata = r_wdata;
    assign words_loaded  = r_words;
endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: frames are built here, and the expected writes, their cycles and the final status follow from the frame contents.
module tb_boot_loader;
    localparam int         TMO  = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        mem_write;
    logic [9:0]  mem_address;
    logic [31:0] mem_writedata;
    logic        cpu_hold, load_done, load_error;
    logic [7:0]  words_loaded;

    boot_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    typedef struct {
        int unsigned cyc;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    wr_t         wq[$];
    wr_t         eq[$];
    logic [31:0] frame_words[$];
    logic [9:0]  last_addr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_write) begin
            wr_t m;
            m.cyc  = cyc;
            m.addr = mem_address;
            m.data = mem_writedata;
            wq.push_back(m);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Callers are always just after a rising edge; each byte is one strobe cycle.
    task automatic drive(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic gap(input int gmax);
        idle($urandom_range(0, gmax));
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wq.size(), eq.size());
        for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
            chk({tag, "_addr"}, {22'd0, wq[i].addr}, {22'd0, eq[i].addr});
            chk({tag, "_data"}, wq[i].data, eq[i].data);
            chk({tag, "_cyc"}, wq[i].cyc, eq[i].cyc);
        end
        wq.delete();
        eq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr"},    mem_write, 0);
        chk({tag, "_addr"},  mem_address, 0);
        chk({tag, "_wdata"}, mem_writedata, 0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_hold"},  cpu_hold, 1);
        chk({tag, "_done"},  load_done, 0);
        chk({tag, "_err"},   load_error, 0);
    endtask

    // Sends SYNC, N and frame_words (plus checksum when enabled); cs_force < 0 sends the correct checksum.
    task automatic send_frame(input int gmax, input int cs_force);
        int          n;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;
        int unsigned c;
        bit          ok;
        wr_t         e;
        n  = frame_words.size();
        cs = 8'h00;
        ok = 1'b1;
        drive(SYNC);
        chk("start_hold",  cpu_hold, 1);
        chk("start_done",  load_done, 0);
        chk("start_err",   load_error, 0);
        chk("start_words", words_loaded, 0);
        chk("start_addr",  mem_address, 0);
        gap(gmax);
        drive(8'(n));
        gap(gmax);
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                b  = w[8*k +: 8];
                cs = cs ^ b;
                c  = cyc;
                drive(b);
                if (k == 3) begin
                    e.cyc  = c + 1;
                    e.addr = 10'(i * 4);
                    e.data = w;
                    eq.push_back(e);
                end
                gap(gmax);
            end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        b  = (cs_force < 0) ? cs : 8'(cs_force);
        ok = (b == cs);
        drive(b);
`else
        if (cs_force >= 0) ok = 1'b1;
`endif
        idle(3);
        last_addr = (wq.size() > 0) ? wq[wq.size()-1].addr : 10'd0;
        check_writes("frame");
        chk("end_done",  load_done, ok);
        chk("end_err",   load_error, !ok);
        chk("end_hold",  cpu_hold, !ok);
        chk("end_words", words_loaded, n);
    endtask

    task automatic random_words(input int lo, input int hi);
        frame_words.delete();
        repeat ($urandom_range(lo, hi)) frame_words.push_back($urandom);
    endtask

    initial begin
        logic [31:0] w;
        int unsigned c;
        wr_t         e;
        int          csf;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        idle(2);

        frame_words = '{32'h00000013, 32'h00100093};
        send_frame(0, -1);

        drive(8'h00);
        drive(8'hFF);
        chk("garbage_nwr", wq.size(), 0);
        frame_words = '{32'hA5A5A5A5};
        send_frame(1, -1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        frame_words = '{32'h44332211};
        send_frame(0, 0);
`endif

        frame_words.delete();
        send_frame(2, -1);

        for (int f = 0; f < 6; f++) begin
            random_words(1, 8);
            csf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            send_frame(3, csf);
        end

        drive(SYNC);
        drive(8'h03);
        drive(8'h01);
        drive(8'h02);
        idle(TMO - 1);
        chk("tmo_early_err", load_error, 0);
        idle(1);
        chk("tmo_err",  load_error, 1);
        chk("tmo_hold", cpu_hold, 1);
        chk("tmo_done", load_done, 0);
        check_writes("tmo");

        random_words(2, 2);
        send_frame(1, -1);

        drive(SYNC);
        drive(8'h04);
        w = $urandom;
        for (int k = 0; k < 4; k++) begin
            c = cyc;
            drive(w[8*k +: 8]);
        end
        e.cyc  = c + 1;
        e.addr = 10'd0;
        e.data = w;
        eq.push_back(e);
        idle(2);
        check_writes("rst_pre");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) drive(8'(k * 17));
        idle(2);
        check_writes("rst_post");
        chk("rst_post_hold", cpu_hold, 1);
        random_words(4, 4);
        send_frame(2, -1);

        random_words(255, 255);
        send_frame(0, -1);
        chk("stream_last_addr", {22'd0, last_addr}, 32'h3F8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
